// File: rtl/vm_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : vm_dispenser
//  Description : Brew/dispense back-end for vmcoffee. Accepts a cup request
//                on a COFFEE rising edge, runs GRIND -> BREW -> POUR -> DONE,
//                and tracks the water-tank and bean-hopper levels that are
//                reported back as WATER/BEANS.
//                Optional feature macro: VM_DISP_STATS_EN (adds CUPS[7:0],
//                a saturating count of completed cups).
//  Revision    : 1.0 - initial release
// ============================================================================
module vm_dispenser #(
  parameter int WATER_W    = 5,
  parameter int WATER_MAX  = 31,
  parameter int CUP_WATER  = 5,
  parameter int BEAN_DOSES = 8,
  parameter int GRIND_CYC  = 4,
  parameter int BREW_CYC   = 8,
  parameter int POUR_CYC   = 3
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active-low
  input  logic               COFFEE,
  input  logic               ERROR,
  input  logic               REFILL_W,
  input  logic               REFILL_B,
  output logic [WATER_W-1:0] WATER,
  output logic               BEANS,
  output logic               BUSY,
  output logic               CUP_READY,
  output logic               FAULT
`ifdef VM_DISP_STATS_EN
  ,
  output logic [7:0]         CUPS
`endif
);

  // Dose counter must hold the full-hopper value.
  localparam int DOSE_W  = $clog2(BEAN_DOSES + 1);

  // Phase counter is sized for the longest phase.
  localparam int MAX_GB  = (GRIND_CYC > BREW_CYC) ? GRIND_CYC : BREW_CYC;
  localparam int MAX_CYC = (MAX_GB > POUR_CYC) ? MAX_GB : POUR_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRIND = 3'd1,
    S_BREW  = 3'd2,
    S_POUR  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    phase;
  logic                coffee_q;
  logic [DOSE_W-1:0]   dose;

  logic                coffee_rise;
  logic                can_brew;
  logic                consume;
  logic [WATER_W-1:0]  water_next;
  logic [DOSE_W-1:0]   dose_next;

  // A request is a rising edge of COFFEE; the previous level is registered.
  assign coffee_rise = COFFEE & ~coffee_q;

  // Enough water for one cup and at least one dose left in the hopper.
  assign can_brew    = (WATER >= WATER_W'(CUP_WATER)) && (dose != '0);

  // Resources are taken exactly on the GRIND -> BREW transition, which is
  // the same edge as GRIND exit (dose) and BREW entry (water). An abort in
  // GRIND wins over this transition, so nothing is consumed in that case.
  assign consume     = (state == S_GRIND) && !ERROR && (phase == '0);

  // Next tank/hopper levels: a refill is applied first, consumption second.
  always_comb begin
    water_next = REFILL_W ? WATER_W'(WATER_MAX) : WATER;
    dose_next  = REFILL_B ? DOSE_W'(BEAN_DOSES) : dose;
    if (consume) begin
      water_next = water_next - WATER_W'(CUP_WATER);
      dose_next  = dose_next - DOSE_W'(1);
    end
  end

  // Tank level, dose count and the registered BEANS flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WATER <= '0;
      dose  <= '0;
      BEANS <= 1'b0;
    end else begin
      WATER <= water_next;
      dose  <= dose_next;
      BEANS <= (dose_next != '0);
    end
  end

  // Brew sequencer: state, phase counter, edge register and pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      phase     <= '0;
      coffee_q  <= 1'b0;
      BUSY      <= 1'b0;
      CUP_READY <= 1'b0;
      FAULT     <= 1'b0;
    end else begin
      coffee_q  <= COFFEE;
      CUP_READY <= 1'b0;
      FAULT     <= 1'b0;
      case (state)
        S_IDLE: begin
          // Requests are rejected while ERROR is up or resources are short;
          // the edge is simply lost in that case.
          if (coffee_rise) begin
            if (ERROR || !can_brew) begin
              FAULT <= 1'b1;
            end else begin
              state <= S_GRIND;
              phase <= CNT_W'(GRIND_CYC - 1);
              BUSY  <= 1'b1;
            end
          end
        end
        S_GRIND: begin
          if (ERROR) begin
            state <= S_IDLE;
            phase <= '0;
            BUSY  <= 1'b0;
            FAULT <= 1'b1;
          end else if (phase == '0) begin
            state <= S_BREW;
            phase <= CNT_W'(BREW_CYC - 1);
          end else begin
            phase <= phase - CNT_W'(1);
          end
        end
        S_BREW: begin
          if (ERROR) begin
            state <= S_IDLE;
            phase <= '0;
            BUSY  <= 1'b0;
            FAULT <= 1'b1;
          end else if (phase == '0) begin
            state <= S_POUR;
            phase <= CNT_W'(POUR_CYC - 1);
          end else begin
            phase <= phase - CNT_W'(1);
          end
        end
        S_POUR: begin
          // Once pouring has started the cup is always finished.
          if (phase == '0) begin
            state     <= S_DONE;
            phase     <= '0;
            CUP_READY <= 1'b1;
          end else begin
            phase <= phase - CNT_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          phase <= '0;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          phase <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

`ifdef VM_DISP_STATS_EN
  // Completed-cup counter, saturating at 255.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      CUPS <= '0;
    end else if (CUP_READY && (CUPS != 8'hFF)) begin
      CUPS <= CUPS + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vm_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vm_dispenser
//  Description : Self-checking bench for vm_dispenser. Cup outcomes (cup or
//                fault) are queued when a request is driven and matched when
//                CUP_READY/FAULT pulse; levels and timing are checked inline.
//                Honours VM_DISP_STATS_EN for the CUPS port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vm_dispenser;

  localparam int WMAX  = 31;
  localparam int CUPW  = 5;
  localparam int DOSES = 8;

  localparam int EV_CUP   = 1;
  localparam int EV_FAULT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       COFFEE = 1'b0;
  logic       ERROR = 1'b0;
  logic       REFILL_W = 1'b0;
  logic       REFILL_B = 1'b0;
  logic [4:0] WATER;
  logic       BEANS;
  logic       BUSY;
  logic       CUP_READY;
  logic       FAULT;
`ifdef VM_DISP_STATS_EN
  logic [7:0] CUPS;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int sb[$];

  int exp_water = 0;
  int exp_dose  = 0;
  int exp_cups  = 0;

  vm_dispenser dut (
    .clk       (clk),
    .rst       (rst),
    .COFFEE    (COFFEE),
    .ERROR     (ERROR),
    .REFILL_W  (REFILL_W),
    .REFILL_B  (REFILL_B),
    .WATER     (WATER),
    .BEANS     (BEANS),
    .BUSY      (BUSY),
    .CUP_READY (CUP_READY),
    .FAULT     (FAULT)
`ifdef VM_DISP_STATS_EN
    ,
    .CUPS      (CUPS)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every CUP_READY/FAULT pulse must match the oldest
  // outstanding expected outcome.
  always @(negedge clk) begin
    int obs_ev;
    int exp_ev;
    if (rst === 1'b1 && (CUP_READY === 1'b1 || FAULT === 1'b1)) begin
      obs_ev = (CUP_READY === 1'b1 ? EV_CUP : 0) + (FAULT === 1'b1 ? EV_FAULT : 0);
      exp_ev = (sb.size() > 0) ? sb.pop_front() : 0;
      chk("sb_event", 32'(obs_ev), 32'(exp_ev));
    end
  end

  task automatic pulse_refill(input bit w, input bit b);
    REFILL_W = w;
    REFILL_B = b;
    step();
    REFILL_W = 1'b0;
    REFILL_B = 1'b0;
    if (w) exp_water = WMAX;
    if (b) exp_dose = DOSES;
  endtask

  // Request that must be rejected from IDLE.
  task automatic rejected_request(input string tag);
    sb.push_back(EV_FAULT);
    COFFEE = 1'b1;
    step();
    COFFEE = 1'b0;
    chk({tag, "_fault"}, 32'(FAULT), 32'd1);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_water"}, 32'(WATER), 32'(exp_water));
    step();
    chk({tag, "_fault_1cyc"}, 32'(FAULT), 32'd0);
  endtask

  // Full cup; optional tank refill on the BREW-entry edge, optional ERROR
  // held across POUR and DONE (must be ignored).
  task automatic run_cup(input bit refill_at_brew, input bit err_in_pour);
    sb.push_back(EV_CUP);
    COFFEE = 1'b1;
    step();
    COFFEE = 1'b0;
    chk("cup_busy_at_n", 32'(BUSY), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      if (i == 4 && refill_at_brew) REFILL_W = 1'b1;
      if (i == 13 && err_in_pour) ERROR = 1'b1;
      step();
      REFILL_W = 1'b0;
      if (i == 3) chk("cup_water_pre_brew", 32'(WATER), 32'(exp_water));
      if (i == 4) begin
        exp_water = (refill_at_brew ? WMAX : exp_water) - CUPW;
        exp_dose  = exp_dose - 1;
        chk("cup_water_brew_entry", 32'(WATER), 32'(exp_water));
        chk("cup_beans", 32'(BEANS), 32'(exp_dose != 0));
      end
      chk("cup_ready_timing", 32'(CUP_READY), 32'(i == 15));
      chk("cup_busy", 32'(BUSY), 32'(i != 16));
    end
    ERROR = 1'b0;
    if (exp_cups < 255) exp_cups++;
  endtask

  initial begin
    // ---- 1: reset, then a request with empty resources ----
    #2 rst = 1'b0;
    #1;
    chk("rst_async_busy", 32'(BUSY), 32'd0);
    step();
    step();
    rst = 1'b1;
    chk("rst_water", 32'(WATER), 32'd0);
    chk("rst_beans", 32'(BEANS), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_cup_ready", 32'(CUP_READY), 32'd0);
    chk("rst_fault", 32'(FAULT), 32'd0);
    rejected_request("empty_req");

    // ---- 2: refills, then one nominal cup ----
    pulse_refill(1'b1, 1'b0);
    chk("refill_w", 32'(WATER), 32'(WMAX));
    pulse_refill(1'b0, 1'b1);
    chk("refill_b", 32'(BEANS), 32'd1);
    run_cup(1'b0, 1'b0);
    chk("cup1_water", 32'(WATER), 32'd26);

    // ---- 3: full hopper gives 8 cups, the 9th is rejected ----
    // Each cup also refills the tank on the BREW-entry edge: refill applies
    // first, so the level must land on WATER_MAX-CUP_WATER.
    pulse_refill(1'b0, 1'b1);
    for (int c = 0; c < 8; c++) run_cup(1'b1, 1'b0);
    chk("hopper_empty_beans", 32'(BEANS), 32'd0);
    chk("refill_then_consume", 32'(WATER), 32'(WMAX - CUPW));
    rejected_request("no_beans_req");

    // ---- 4: tank below one cup with beans present ----
    pulse_refill(1'b0, 1'b1);
    run_cup(1'b0, 1'b0);
    run_cup(1'b0, 1'b1);
    run_cup(1'b0, 1'b0);
    run_cup(1'b0, 1'b0);
    run_cup(1'b0, 1'b0);
    chk("low_tank_level", 32'(WATER), 32'd1);
    rejected_request("low_water_req");
    chk("low_water_beans", 32'(BEANS), 32'd1);

    // ---- 5: ERROR abort in BREW, ignored edge while busy ----
    pulse_refill(1'b1, 1'b0);
    sb.push_back(EV_FAULT);
    COFFEE = 1'b1;
    step();
    COFFEE = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 2) COFFEE = 1'b1;
      if (i == 3) COFFEE = 1'b0;
      if (i == 4) begin
        exp_water = exp_water - CUPW;
        exp_dose  = exp_dose - 1;
        chk("abort_water_brew", 32'(WATER), 32'(exp_water));
      end
    end
    ERROR = 1'b1;
    step();
    chk("abort_idle", 32'(BUSY), 32'd0);
    chk("abort_fault", 32'(FAULT), 32'd1);
    chk("abort_water_kept", 32'(WATER), 32'd26);
    // ERROR still high in IDLE: the request is lost with a FAULT.
    rejected_request("error_idle_req");
    ERROR = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("abort_no_cup", 32'(CUP_READY), 32'd0);
    end
    chk("abort_busy_quiet", 32'(BUSY), 32'd0);

    // ---- 6: asynchronous reset mid-BREW ----
`ifdef VM_DISP_STATS_EN
    chk("cups_count", 32'(CUPS), 32'(exp_cups));
`endif
    COFFEE = 1'b1;
    step();
    COFFEE = 1'b0;
    for (int i = 1; i <= 10; i++) step();
    chk("midbrew_busy", 32'(BUSY), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_water", 32'(WATER), 32'd0);
    chk("arst_beans", 32'(BEANS), 32'd0);
    chk("arst_busy", 32'(BUSY), 32'd0);
    chk("arst_cup_ready", 32'(CUP_READY), 32'd0);
    chk("arst_fault", 32'(FAULT), 32'd0);
`ifdef VM_DISP_STATS_EN
    chk("arst_cups", 32'(CUPS), 32'd0);
`endif
    exp_water = 0;
    exp_dose  = 0;
    exp_cups  = 0;
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("post_rst_no_cup", 32'(CUP_READY), 32'd0);
    end
    rejected_request("post_rst_req");

`ifdef VM_DISP_STATS_EN
    pulse_refill(1'b1, 1'b1);
    run_cup(1'b0, 1'b0);
    run_cup(1'b0, 1'b0);
    chk("cups_two", 32'(CUPS), 32'd2);
    rst = 1'b0;
    #1;
    chk("cups_rst", 32'(CUPS), 32'd0);
    step();
    rst = 1'b1;
`endif

    step();
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
